// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for a fetch unit, with a side port for program load.
// Latency: a request accepted on edge N raises rsp_valid_out after edge N+WAIT_CYCLES.
//   The read is sampled on the edge that enters RESP.
// Backpressure: rsp_valid_out holds in RESP until rsp_ready_in. req_ready_out is high only in IDLE.
// Ports: clk_in/rst_in (sync, active-low); req_* fetch request; rsp_* fetch response;
//        load_* program-load write port (active in every state, ignored in reset).
// Optional macro IMEM_FAULT_CHECK_EN flags misaligned or out-of-range fetches.
//   Such fetches return err=1 and a NOP. Without the macro, addresses wrap modulo the depth.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  input  logic [31:0] req_addr_in,
  output logic        req_ready_out,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_data_out,
  output logic        rsp_err_out,
  input  logic        rsp_ready_in,
  input  logic        load_en_in,
  input  logic [31:0] load_addr_in,
  input  logic [31:0] load_data_in
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // Memory has no reset so a loaded program survives a core reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_fault;
  logic        unused_addr_bits;

  // With zero wait states the read happens on the acceptance edge itself,
  // so the address has to come straight from the request port.
  assign rd_addr = (state_q == S_IDLE) ? req_addr_in : addr_q;
  assign rd_word = mem_q[rd_addr[AW+1:2]];

`ifdef IMEM_FAULT_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  assign rd_fault = (rd_addr[1:0] != 2'b00) || ({1'b0, rd_addr} >= ADDR_LIMIT);
`else
  assign rd_fault = 1'b0;
`endif

  assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], load_addr_in[31:AW]};

  assign req_ready_out = (state_q == S_IDLE);
  assign rsp_valid_out = (state_q == S_RESP);
  assign rsp_data_out  = data_q;
  assign rsp_err_out   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_in) begin
          addr_d = req_addr_in;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            data_d  = rd_fault ? NOP_WORD : rd_word;
            err_d   = rd_fault;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          data_d  = rd_fault ? NOP_WORD : rd_word;
          err_d   = rd_fault;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Going back to IDLE only; a request seen on this edge is not taken.
        if (rsp_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // The read above uses the pre-edge contents, so a same-edge load is seen by the next fetch only.
  always_ff @(posedge clk_in) begin
    if (rst_in && load_en_in) begin
      mem_q[load_addr_in[AW-1:0]] <= load_data_in;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder.
// The main instance uses WAIT_CYCLES=2 and DEPTH 1024. A second instance uses WAIT_CYCLES=0 and DEPTH 16.
// Expected responses come from a word-array model of the loaded program.
module tb_imem_responder;
  localparam int DEPTH  = 1024;
  localparam int WAITC  = 2;
  localparam int DEPTH0 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_err, rsp_ready, load_en;
  logic [31:0] req_addr, rsp_data, load_addr, load_data;
  logic        rst0_n, req_valid0, req_ready0, rsp_valid0, rsp_err0, rsp_ready0, load_en0;
  logic [31:0] req_addr0, rsp_data0, load_addr0, load_data0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .req_valid_in(req_valid), .req_addr_in(req_addr),
    .req_ready_out(req_ready), .rsp_valid_out(rsp_valid), .rsp_data_out(rsp_data),
    .rsp_err_out(rsp_err), .rsp_ready_in(rsp_ready), .load_en_in(load_en),
    .load_addr_in(load_addr), .load_data_in(load_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) u_dut0 (
    .clk_in(clk), .rst_in(rst0_n), .req_valid_in(req_valid0), .req_addr_in(req_addr0),
    .req_ready_out(req_ready0), .rsp_valid_out(rsp_valid0), .rsp_data_out(rsp_data0),
    .rsp_err_out(rsp_err0), .rsp_ready_in(rsp_ready0), .load_en_in(load_en0),
    .load_addr_in(load_addr0), .load_data_in(load_data0)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {err, data} for a fetch at byte address a.
  function automatic logic [32:0] model(input logic [31:0] a);
`ifdef IMEM_FAULT_CHECK_EN
    if ((a % 4) != 0 || a >= 32'(4 * DEPTH)) return {1'b1, 32'h0000_0013};
`endif
    return {1'b0, ref_mem[(a / 4) % DEPTH]};
  endfunction

  task automatic load(input logic [31:0] idx, input logic [31:0] val);
    load_en = 1'b1; load_addr = idx; load_data = val;
    tick();
    load_en = 1'b0;
    ref_mem[idx % DEPTH] = val;
  endtask

  // One full fetch: accept, measure latency, hold under backpressure, release.
  task automatic do_req(input logic [31:0] a, input int hold, input bit poke);
    logic [32:0] e;
    int lat;
    e = model(a);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0; req_addr = $urandom;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(WAITC));
    check("rsp_data", rsp_data, e[31:0]);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
    rsp_ready = 1'b0;
    req_valid = poke;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", rsp_data, e[31:0]);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("release_valid", {31'd0, rsp_valid}, 32'd0);
    check("release_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    rst0_n = 1'b0; req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
    load_en0 = 1'b0; load_addr0 = '0; load_data0 = '0;
    tick(); tick();
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1; rst0_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) load(32'(i), $urandom);

    // Basic fetch, backpressure, and address corner cases.
    load(32'd5, 32'hDEAD_BEEF);
    do_req(32'h14, 0, 1'b0);
    do_req(32'h14, 10, 1'b1);
    do_req(32'h6, 0, 1'b0);
    do_req(32'h1000, 0, 1'b0);

    // Reset while in WAIT, with a load attempted during reset.
    load(32'd7, 32'hA5A5_0007);
    req_valid = 1'b1; req_addr = 32'h1C;
    tick();
    req_valid = 1'b0;
    check("wait_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0; load_en = 1'b1; load_addr = 32'd7; load_data = 32'h0000_0BAD;
    tick();
    load_en = 1'b0; rst_n = 1'b1;
    check("rstwait_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstwait_ready", {31'd0, req_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) n++;
    end
    check("abandoned_no_rsp", 32'(n), 32'd0);
    do_req(32'h1C, 0, 1'b0);
    do_req(32'h14, 1, 1'b0);

    // Reset while in RESP.
    req_valid = 1'b1; req_addr = 32'h20;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("resp_before_rst", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstresp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstresp_data", rsp_data, 32'd0);

    // Load and read of word 3 on the same edge returns the old word.
    load(32'd3, 32'h1);
    req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    tick();
    load_en = 1'b1; load_addr = 32'd3; load_data = 32'h2;
    tick();
    load_en = 1'b0; ref_mem[3] = 32'h2;
    check("rbw_valid", {31'd0, rsp_valid}, 32'd1);
    check("rbw_data", rsp_data, 32'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    do_req(32'hC, 0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) load($urandom, $urandom);
      case ($urandom_range(0, 3))
        0: a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
        1: a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        2: a = $urandom;
        default: a = 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      do_req(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Zero-wait instance: single fetch and back-to-back throughput.
    load_en0 = 1'b1; load_addr0 = 32'd0; load_data0 = 32'h0050_0093;
    tick();
    load_en0 = 1'b0;
    req_valid0 = 1'b1; req_addr0 = 32'h0;
    tick();
    req_valid0 = 1'b0;
    check("w0_valid", {31'd0, rsp_valid0}, 32'd1);
    check("w0_data", rsp_data0, 32'h0050_0093);
    check("w0_err", {31'd0, rsp_err0}, 32'd0);
    rsp_ready0 = 1'b1;
    tick();
    check("w0_idle", {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid0 === 1'b1) n++;
    end
    req_valid0 = 1'b0;
    check("w0_b2b_count", 32'(n), 32'd4);
    tick(); tick();
    rsp_ready0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
